// File: rtl/db15_pad_responder_if.sv
// Serial link between the DB15 joystick reader (master) and the pad responder (slave).
interface db15_pad_responder_if;
   logic joy_load;
   logic joy_clk;
   logic joy_data;

   modport master (output joy_load, output joy_clk, input joy_data);
   modport slave  (input joy_load, input joy_clk, output joy_data);
endinterface

// File: rtl/db15_pad_responder.sv
// Two-player SNAC DB15 pad responder: loads both pads on joy_load low and shifts the frame out on joy_clk rises.
// Optional input glitch filter enabled by defining DB15_GLITCH_FILTER_EN.
module db15_pad_responder #(
   parameter int unsigned FRAME_BITS  = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic                 i_clk,
   input  logic                 RESETn,
   db15_pad_responder_if.slave  bus,
   input  logic [11:0]          joystick1,
   input  logic [11:0]          joystick2,
   output logic [4:0]           bit_cnt,
   output logic                 frame_done
);

   localparam int unsigned CNT_W = 5;
   localparam int unsigned N_IN  = 2;
   localparam int unsigned I_CLK = 0;
   localparam int unsigned I_LD  = 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SHIFTING = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   if (FRAME_BITS < 2 || FRAME_BITS > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       FILT_CYCLES < 1) begin : g_param_err
      $error("db15_pad_responder: parameter out of legal range");
   end

   logic [N_IN-1:0]        pin;
   logic [SYNC_STAGES-1:0] sync_q [N_IN];
   logic [N_IN-1:0]        synced;
   logic [N_IN-1:0]        lvl;
   logic                   clk_prev;
   logic                   clk_rise;
   logic [FRAME_BITS-1:0]  shreg;
   logic [FRAME_BITS-1:0]  load_val;
   state_t                 state;

   assign pin[I_CLK] = bus.joy_clk;
   assign pin[I_LD]  = bus.joy_load;

   // Synchronizers preset high so an idle-high line after reset is not an edge.
   for (genvar g = 0; g < N_IN; g++) begin : g_sync
      always_ff @(posedge i_clk or negedge RESETn) begin
         if (!RESETn) begin
            sync_q[g] <= '1;
         end else begin
            sync_q[g] <= {sync_q[g][SYNC_STAGES-2:0], pin[g]};
         end
      end
      assign synced[g] = sync_q[g][SYNC_STAGES-1];
   end

`ifdef DB15_GLITCH_FILTER_EN
   localparam int unsigned FW = $clog2(FILT_CYCLES + 1);

   logic [FW-1:0] fcnt [N_IN];

   // Filtered level follows the synced input only after FILT_CYCLES stable cycles.
   for (genvar g = 0; g < N_IN; g++) begin : g_filt
      always_ff @(posedge i_clk or negedge RESETn) begin
         if (!RESETn) begin
            fcnt[g] <= '0;
            lvl[g]  <= 1'b1;
         end else if (synced[g] == lvl[g]) begin
            fcnt[g] <= '0;
         end else if (fcnt[g] == FW'(FILT_CYCLES - 1)) begin
            fcnt[g] <= '0;
            lvl[g]  <= synced[g];
         end else begin
            fcnt[g] <= fcnt[g] + FW'(1);
         end
      end
   end
`else
   assign lvl = synced;
`endif

   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         clk_prev <= 1'b1;
      end else begin
         clk_prev <= lvl[I_CLK];
      end
   end

   assign clk_rise = lvl[I_CLK] & ~clk_prev;

   // Unused high frame bits (FRAME_BITS > 24) load as released buttons.
   assign load_val = ~FRAME_BITS'({joystick2, joystick1});

   // Frame FSM: load has priority over any coincident shift edge.
   always_ff @(posedge i_clk or negedge RESETn) begin
      if (!RESETn) begin
         state      <= S_IDLE;
         shreg      <= '1;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!lvl[I_LD]) begin
            state   <= S_IDLE;
            shreg   <= load_val;
            bit_cnt <= '0;
         end else if (clk_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], 1'b1};
            if (state != S_DONE) begin
               bit_cnt <= bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                  state      <= S_DONE;
                  frame_done <= (state == S_SHIFTING);
               end else begin
                  state <= S_SHIFTING;
               end
            end
         end
      end
   end

   assign bus.joy_data = shreg[FRAME_BITS-1];

endmodule
